// File: rtl/kernel_window_ctrl.sv
// kernel_window_ctrl: 3x3 window sequencer for a combinational conv kernel.
// Raster pixels in, two line buffers feed nine taps, one pixel out per pixel in.
// Ports: clk, rst_n (async, active-low); start/busy/done frame control;
//   in_data/in_valid/in_ready pixel input; win_p0..win_p8 taps (p0 top-left);
//   kern_result from kernel; out_data/out_valid/out_ready pixel output.
// Build option: BORDER_PASS_EN passes the centre pixel on border outputs
//   instead of zero.
module kernel_window_ctrl #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] win_p0,
  output logic [PIX_W-1:0] win_p1,
  output logic [PIX_W-1:0] win_p2,
  output logic [PIX_W-1:0] win_p3,
  output logic [PIX_W-1:0] win_p4,
  output logic [PIX_W-1:0] win_p5,
  output logic [PIX_W-1:0] win_p6,
  output logic [PIX_W-1:0] win_p7,
  output logic [PIX_W-1:0] win_p8,
  input  logic [PIX_W-1:0] kern_result,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FLSH = 2'd3;

  logic [1:0]    st_q, st_d;
  logic [CW-1:0] col_q, ocol_q;
  logic [RW-1:0] row_q, orow_q;
  logic [FW-1:0] fcnt_q;
  logic          s1_q, ov_q, last_q, done_q;
  logic [7:0]    od_q;
  logic [7:0]    w_q [9];
  logic [7:0]    lb0_q [IMG_W];
  logic [7:0]    lb1_q [IMG_W];

  logic       go, stall, acc, fl_step, step, cap, hs;
  logic       col_last, row_last, ocol_last, orow_last, border;
  logic [7:0] pix, bval, lb0_rd, lb1_rd;
  logic       unused_kr;

  assign unused_kr = ^kern_result[PIX_W-1:8];

  assign col_last  = (col_q == CW'(IMG_W - 1));
  assign row_last  = (row_q == RW'(IMG_H - 1));
  assign ocol_last = (ocol_q == CW'(IMG_W - 1));
  assign orow_last = (orow_q == RW'(IMG_H - 1));
  assign border    = (orow_q == '0) || orow_last ||
                     (ocol_q == '0) || ocol_last;

  assign go    = start && (st_q == S_IDLE);
  // Stage 1 cannot be overwritten while stage 2 holds an unaccepted pixel.
  assign stall = s1_q && ov_q && !out_ready;
  assign in_ready = (st_q == S_FILL) ||
                    ((st_q == S_RUN) && !stall);
  assign acc     = in_valid && in_ready;
  assign fl_step = (st_q == S_FLSH) && !stall &&
                   (fcnt_q != FW'(IMG_W + 1));
  assign step = acc || fl_step;
  assign pix  = acc ? in_data : 8'd0;
  assign cap  = s1_q && (!ov_q || out_ready);
  assign hs   = ov_q && out_ready;

  assign lb0_rd = lb0_q[col_q];
  assign lb1_rd = lb1_q[col_q];

`ifdef BORDER_PASS_EN
  assign bval = w_q[4];
`else
  assign bval = 8'd0;
`endif

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE: if (start) st_d = S_FILL;
      S_FILL:
        if (acc && row_q == RW'(1) && col_q == '0)
          st_d = S_RUN;
      S_RUN:
        if (acc && row_last && col_last)
          st_d = S_FLSH;
      S_FLSH: if (hs && last_q) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // Line buffer contents need no reset: stale data only
  // ever reaches border outputs.
  always_ff @(posedge clk) begin
    if (step) begin
      lb1_q[col_q] <= lb0_rd;
      lb0_q[col_q] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      col_q  <= '0;
      row_q  <= '0;
      fcnt_q <= '0;
      ocol_q <= '0;
      orow_q <= '0;
      s1_q   <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < 9; i++) w_q[i] <= '0;
    end else begin
      st_q   <= st_d;
      done_q <= (st_q == S_FLSH) && hs && last_q;
      if (go) begin
        col_q  <= '0;
        row_q  <= '0;
        fcnt_q <= '0;
        ocol_q <= '0;
        orow_q <= '0;
        last_q <= 1'b0;
      end else begin
        if (step) begin
          col_q <= col_last ? '0 : col_q + CW'(1);
          if (col_last && !row_last)
            row_q <= row_q + RW'(1);
          // FILL steps only prime the window.
          s1_q <= (st_q != S_FILL);
          w_q[0] <= w_q[1];
          w_q[1] <= w_q[2];
          w_q[2] <= lb1_rd;
          w_q[3] <= w_q[4];
          w_q[4] <= w_q[5];
          w_q[5] <= lb0_rd;
          w_q[6] <= w_q[7];
          w_q[7] <= w_q[8];
          w_q[8] <= pix;
        end else if (cap) begin
          s1_q <= 1'b0;
        end
        if (fl_step) fcnt_q <= fcnt_q + FW'(1);
        if (cap) begin
          ov_q   <= 1'b1;
          od_q   <= border ? bval : kern_result[7:0];
          last_q <= orow_last && ocol_last;
          if (ocol_last) begin
            ocol_q <= '0;
            orow_q <= orow_last ? '0 : orow_q + RW'(1);
          end else begin
            ocol_q <= ocol_q + CW'(1);
          end
        end else if (hs) begin
          ov_q <= 1'b0;
        end
      end
    end
  end

  assign busy      = (st_q != S_IDLE);
  assign done      = done_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;

  assign win_p0 = PIX_W'(w_q[0]);
  assign win_p1 = PIX_W'(w_q[1]);
  assign win_p2 = PIX_W'(w_q[2]);
  assign win_p3 = PIX_W'(w_q[3]);
  assign win_p4 = PIX_W'(w_q[4]);
  assign win_p5 = PIX_W'(w_q[5]);
  assign win_p6 = PIX_W'(w_q[6]);
  assign win_p7 = PIX_W'(w_q[7]);
  assign win_p8 = PIX_W'(w_q[8]);

endmodule

// File: tb/tb_kernel_window_ctrl.sv
// tb_kernel_window_ctrl: directed bench for kernel_window_ctrl, 8x6 frame,
// outline kernel modelled here; build with BORDER_PASS_EN to test that option.
module tb_kernel_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int PW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] win_p0, win_p1, win_p2, win_p3, win_p4;
  logic [PW-1:0] win_p5, win_p6, win_p7, win_p8;
  logic [PW-1:0] kern_result;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int pix_mem [N];
  int out_first [N];
  int obs [$];

  always #5 clk = ~clk;

  kernel_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win_p0(win_p0), .win_p1(win_p1), .win_p2(win_p2),
    .win_p3(win_p3), .win_p4(win_p4), .win_p5(win_p5),
    .win_p6(win_p6), .win_p7(win_p7), .win_p8(win_p8),
    .kern_result(kern_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Outline kernel: 8*centre minus the eight neighbours, clipped 0..255.
  int ks;
  always_comb begin
    ks = 8 * int'(win_p4) - int'(win_p0) - int'(win_p1) - int'(win_p2)
       - int'(win_p3) - int'(win_p5) - int'(win_p6) - int'(win_p7)
       - int'(win_p8);
    if (ks < 0) ks = 0;
    if (ks > 255) ks = 255;
    kern_result = PW'(ks);
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  function automatic int golden(int r, int c);
    int s;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
`ifdef BORDER_PASS_EN
      return pix_mem[r*W+c];
`else
      return 0;
`endif
    end
    s = 9 * pix_mem[r*W+c];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s -= pix_mem[(r+dr)*W + c + dc];
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic int obs_at(int k);
    return (k < obs.size()) ? obs[k] : -1;
  endfunction

  task automatic run_frame(input int gap, input bit rnd,
                           input int stop_at, input bit extra,
                           input bit lat);
    int n_acc, dones, after, done_cyc;
    bit acc, seen, pv, hold;
    logic [7:0] pd;
    n_acc = 0; dones = 0; after = 0; done_cyc = -1;
    seen = 0; pv = 0; hold = 0; pd = 8'd0;
    obs.delete();
    for (int k = 0; k < N; k++) out_first[k] = -1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      start = (cyc == 0) ||
              (extra && (cyc == 4 || cyc == 25 || cyc == 52));
      in_valid = (n_acc < N) && (hold || (cyc % gap) == 0);
      in_data = 8'(pix_mem[(n_acc < N) ? n_acc : 0]);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      hold = in_valid && !in_ready;
      if (cyc == 2) chk("busy_hi", busy, 1);
      if (pv) begin
        chk("hold_v", out_valid, 1);
        chk("hold_d", out_data, pd);
      end
      if (gap == 1 && out_valid && !out_ready && busy)
        chk("stall_rdy", in_ready, 0);
      if (out_valid) begin
        if (!seen && obs.size() < N) out_first[obs.size()] = cyc;
        seen = 1;
        if (out_ready) begin
          obs.push_back(int'(out_data));
          seen = 0;
        end
      end
      pv = out_valid && !out_ready;
      pd = out_data;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (dones > 0) after++;
      @(posedge clk);
      #1;
      if (acc) n_acc++;
      if (stop_at > 0 && n_acc >= stop_at) break;
      if (after >= 3) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (stop_at == 0) begin
      chk("done_cnt", dones, 1);
      chk("n_out", obs.size(), N);
      chk("busy_end", busy, 0);
      for (int k = 0; k < N; k++)
        chk($sformatf("out%0d", k), obs_at(k), golden(k / W, k % W));
      if (lat) begin
        for (int k = 0; k < N; k++)
          chk($sformatf("lat%0d", k), out_first[k], k + 12);
        chk("done_cyc", done_cyc, 60);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_rdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_p0", win_p0, 0);
    chk("rst_p4", win_p4, 0);
    chk("rst_p8", win_p8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_rdy", in_ready, 0);

    // constant frame, full throughput, latency
    for (int i = 0; i < N; i++) pix_mem[i] = 100;
    run_frame(1, 0, 0, 0, 1);

    // impulse
    for (int i = 0; i < N; i++) pix_mem[i] = 0;
    pix_mem[2*W+3] = 40;
`ifdef BORDER_PASS_EN
    pix_mem[0] = 77;
`endif
    run_frame(1, 0, 0, 0, 0);
    chk("imp_c", obs_at(2*W+3), 255);
    chk("imp_n", obs_at(2*W+2), 0);
    chk("imp_s", obs_at(3*W+3), 0);
`ifdef BORDER_PASS_EN
    chk("pass00", obs_at(0), 77);
`endif

    // ramp and random frames with random back-pressure
    for (int i = 0; i < N; i++) pix_mem[i] = 8*(i / W) + (i % W);
    run_frame(1, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) pix_mem[i] = $urandom_range(0, 255);
    run_frame(1, 1, 0, 0, 0);

    // gapped input
    for (int i = 0; i < N; i++) pix_mem[i] = 8*(i / W) + (i % W);
    run_frame(3, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) pix_mem[i] = $urandom_range(0, 255);
    run_frame(3, 1, 0, 0, 0);

    // abort by reset after 20 inputs
    run_frame(1, 0, 20, 0, 0);
    chk("pre_ov", out_valid, 1);
    chk("pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_rdy", in_ready, 0);
    chk("ab_ov", out_valid, 0);
    chk("ab_od", out_data, 0);
    chk("ab_p0", win_p0, 0);
    chk("ab_p4", win_p4, 0);
    chk("ab_p8", win_p8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) pix_mem[i] = 50;
    run_frame(1, 0, 0, 0, 0);

    // spurious starts in FILL, RUN, FLUSH, then a second frame
    for (int i = 0; i < N; i++) pix_mem[i] = $urandom_range(0, 255);
    run_frame(1, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) pix_mem[i] = (i * 37) % 256;
    run_frame(1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
